// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared definitions for the instruction fetch stage.
//   DATA_WIDTH     - width of PC, fetch address, instruction word and retire counter
//   INSTR_BYTES    - bytes per instruction; sequential PC step
//   ifetch_state_t - fetch stage FSM states, also exported on the debug port
//   pc_aligned()   - true when an address is a legal instruction address
package ifetch_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int INSTR_BYTES = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_TRAP   = 3'd4
  } ifetch_state_t;

  function automatic logic pc_aligned(input logic [DATA_WIDTH-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/ifetch_if.sv
// Request/response bundles used by the fetch stage.
//   ifetch_imem_if - fetch stage (master) to instruction memory (slave):
//                    req_valid, addr out; resp_valid, rdata in.
//   ifetch_dec_if  - fetch stage (master) to decoder (slave):
//                    req_valid, instruction out; resp_valid in.
//
// Handshake: req_valid is a level held by the master until the slave answers
// with a single-cycle resp_valid pulse. Payloads driven by the master (addr,
// instruction) are stable while req_valid is high; rdata is only meaningful
// in the cycle resp_valid is high. req_valid drops the cycle after the pulse
// is sampled, and may also be withdrawn early by reset, which the slave must
// tolerate.

interface ifetch_imem_if;
  logic                             req_valid;
  logic [ifetch_pkg::DATA_WIDTH-1:0] addr;
  logic                             resp_valid;
  logic [ifetch_pkg::DATA_WIDTH-1:0] rdata;

  modport master (output req_valid, output addr, input resp_valid, input rdata);
  modport slave  (input req_valid, input addr, output resp_valid, output rdata);
endinterface

interface ifetch_dec_if;
  logic                             req_valid;
  logic [ifetch_pkg::DATA_WIDTH-1:0] instruction;
  logic                             resp_valid;

  modport master (output req_valid, output instruction, input resp_valid);
  modport slave  (input req_valid, input instruction, output resp_valid);
endinterface

// File: rtl/ifetch.sv
// ifetch: non-pipelined instruction fetch stage. Holds the PC, fetches one
// word from instruction memory, hands it to the decoder, then waits for
// execute to report the next-PC decision. One instruction in flight at a time.
//
// Ports:
//   clk, rst     - clock and synchronous active-high reset
//   run          - start/continue fetching (sampled in IDLE and at EXEC exit)
//   imem         - instruction memory request/response bundle (master)
//   dec          - decoder request/response bundle (master)
//   exec_done    - pulse: execute finished the current instruction
//   exec_taken   - with exec_done: take exec_target instead of pc+4
//   exec_target  - redirect PC
//   pc           - PC of the instruction in flight
//   retired      - completed instruction count, wraps
//   trap         - sticky misaligned-target flag; only rst clears it
//   dbg_state    - current FSM state
module ifetch
  import ifetch_pkg::*;
#(
  parameter logic [DATA_WIDTH-1:0] RESET_PC = '0  // must be 4-byte aligned
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  ifetch_imem_if.master         imem,
  ifetch_dec_if.master          dec,
  input  logic                  exec_done,
  input  logic                  exec_taken,
  input  logic [DATA_WIDTH-1:0] exec_target,
  output logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] retired,
  output logic                  trap,
  output ifetch_state_t         dbg_state
);

  ifetch_state_t         state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] retired_q, retired_d;
  logic                  trap_q, trap_d;
  logic                  imem_req_q, imem_req_d;
  logic                  dec_req_q, dec_req_d;
  logic [DATA_WIDTH-1:0] next_pc;

  // Next-PC selection; the sequential step wraps naturally at 2^32.
  always_comb begin
    next_pc = exec_taken ? exec_target : (pc_q + DATA_WIDTH'(INSTR_BYTES));
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    trap_d    = trap_q;

    case (state_q)
      ST_IDLE: begin
        if (run) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem.resp_valid) begin
          instr_d = imem.rdata;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec.resp_valid) state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (exec_done) begin
          // A misaligned branch still completed, so it is counted.
          retired_d = retired_q + DATA_WIDTH'(1);
          if (!pc_aligned(next_pc)) begin
            trap_d  = 1'b1;
            state_d = ST_TRAP;
          end else begin
            pc_d    = next_pc;
            state_d = run ? ST_FETCH : ST_IDLE;
          end
        end
      end
      ST_TRAP: begin
        trap_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Requests are registered copies of the current state: they rise one
    // cycle after entering FETCH/DECODE and fall one cycle after leaving.
    imem_req_d = (state_q == ST_FETCH);
    dec_req_d  = (state_q == ST_DECODE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      retired_q  <= '0;
      trap_q     <= 1'b0;
      imem_req_q <= 1'b0;
      dec_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      retired_q  <= retired_d;
      trap_q     <= trap_d;
      imem_req_q <= imem_req_d;
      dec_req_q  <= dec_req_d;
    end
  end

  assign imem.req_valid  = imem_req_q;
  assign imem.addr       = pc_q;
  assign dec.req_valid   = dec_req_q;
  assign dec.instruction = instr_q;
  assign pc              = pc_q;
  assign retired         = retired_q;
  assign trap            = trap_q;
  assign dbg_state       = state_q;

endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: self-checking bench for ifetch. A behavioural model tracks the
// architectural PC, retire count and trap flag per instruction; a queue holds
// the fetch addresses the model expects to see next.
module tb_ifetch;
  import ifetch_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          run;
  logic          exec_done;
  logic          exec_taken;
  logic [31:0]   exec_target;
  logic [31:0]   pc;
  logic [31:0]   retired;
  logic          trap;
  ifetch_state_t dbg_state;

  ifetch_imem_if imem_bus ();
  ifetch_dec_if  dec_bus ();

  ifetch #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .imem        (imem_bus),
    .dec         (dec_bus),
    .exec_done   (exec_done),
    .exec_taken  (exec_taken),
    .exec_target (exec_target),
    .pc          (pc),
    .retired     (retired),
    .trap        (trap),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] m_pc;
  logic [31:0] m_retired;
  logic        m_trap;
  logic [31:0] exp_q[$];

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_reset();
    m_pc      = RESET_PC;
    m_retired = 32'd0;
    m_trap    = 1'b0;
    exp_q.delete();
  endtask

  task automatic apply_reset(input int n);
    rst = 1'b1;
    imem_bus.resp_valid = 1'b0;
    dec_bus.resp_valid  = 1'b0;
    exec_done = 1'b0;
    cyc(n);
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_imem_req(output bit ok);
    int n = 0;
    while (imem_bus.req_valid !== 1'b1 && n < 64) begin
      cyc(1);
      n++;
    end
    ok = (imem_bus.req_valid === 1'b1);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL imem_req_wait: req_valid=%b required 1 within 64 cycles", imem_bus.req_valid);
    end
  endtask

  task automatic wait_dec_req(output bit ok);
    int n = 0;
    while (dec_bus.req_valid !== 1'b1 && n < 64) begin
      cyc(1);
      n++;
    end
    ok = (dec_bus.req_valid === 1'b1);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL dec_req_wait: req_valid=%b required 1 within 64 cycles", dec_bus.req_valid);
    end
  endtask

  // Memory side: wait for the request, check the address against the
  // scoreboard, answer after lat cycles.
  task automatic fetch_phase(input logic [31:0] instr, input int lat);
    bit ok;
    logic [31:0] exp;
    wait_imem_req(ok);
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL fetch_addr: got fetch of %h, required no fetch", imem_bus.addr);
    end else begin
      exp = exp_q.pop_front();
      if (imem_bus.addr !== exp) begin
        failures++;
        $display("FAIL fetch_addr: got %h required %h", imem_bus.addr, exp);
      end
    end
    cyc(lat);
    imem_bus.resp_valid = 1'b1;
    imem_bus.rdata      = instr;
    cyc(1);
    imem_bus.resp_valid = 1'b0;
    imem_bus.rdata      = $urandom;
  endtask

  task automatic decode_phase(input logic [31:0] instr, input int lat);
    bit ok;
    wait_dec_req(ok);
    checks++;
    if (dec_bus.instruction !== instr) begin
      failures++;
      $display("FAIL dec_instruction: got %h required %h", dec_bus.instruction, instr);
    end
    checks++;
    if (pc !== m_pc) begin
      failures++;
      $display("FAIL decode_pc: got %h required %h", pc, m_pc);
    end
    cyc(lat);
    dec_bus.resp_valid = 1'b1;
    cyc(1);
    dec_bus.resp_valid = 1'b0;
  endtask

  task automatic exec_phase(input int lat, input bit taken, input logic [31:0] target,
                            input bit run_after);
    logic [31:0]   nxt;
    ifetch_state_t exp_state;
    cyc(lat);
    exec_done   = 1'b1;
    exec_taken  = taken;
    exec_target = target;
    run         = run_after;
    cyc(1);
    exec_done   = 1'b0;
    exec_taken  = 1'($urandom);
    exec_target = $urandom;
    // Reference model: one instruction completes.
    m_retired = m_retired + 32'd1;
    nxt = taken ? target : m_pc + 32'd4;
    if (nxt % 4 != 0) begin
      m_trap = 1'b1;
    end else begin
      m_pc = nxt;
      if (run_after) exp_q.push_back(nxt);
    end
    exp_state = m_trap ? ST_TRAP : (run_after ? ST_FETCH : ST_IDLE);
    checks++;
    if (retired !== m_retired) begin
      failures++;
      $display("FAIL retired: got %0d required %0d", retired, m_retired);
    end
    checks++;
    if (trap !== m_trap) begin
      failures++;
      $display("FAIL trap: got %b required %b", trap, m_trap);
    end
    checks++;
    if (pc !== m_pc) begin
      failures++;
      $display("FAIL exec_pc: got %h required %h", pc, m_pc);
    end
    checks++;
    if (dbg_state !== exp_state) begin
      failures++;
      $display("FAIL exec_state: got %0d required %0d", dbg_state, exp_state);
    end
  endtask

  task automatic run_instr(input logic [31:0] instr, input int ml, input int dl, input int el,
                           input bit taken, input logic [31:0] target, input bit run_after);
    fetch_phase(instr, ml);
    decode_phase(instr, dl);
    exec_phase(el, taken, target, run_after);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    run = 1'b0;
    apply_reset(2);
    checks++;
    if (imem_bus.req_valid !== 1'b0 || dec_bus.req_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_req: imem=%b dec=%b required 0 0", imem_bus.req_valid, dec_bus.req_valid);
    end
    checks++;
    if (pc !== RESET_PC || retired !== 32'd0 || trap !== 1'b0) begin
      failures++;
      $display("FAIL reset_regs: pc=%h retired=%0d trap=%b required %h 0 0", pc, retired, trap, RESET_PC);
    end
    checks++;
    if (dbg_state !== ST_IDLE || dec_bus.instruction !== 32'd0) begin
      failures++;
      $display("FAIL reset_state: state=%0d instr=%h required 0 0", dbg_state, dec_bus.instruction);
    end
    run = 1'b1;
    exp_q.push_back(m_pc);
    cyc(1);
    checks++;
    if (imem_bus.req_valid !== 1'b0 || dbg_state !== ST_FETCH) begin
      failures++;
      $display("FAIL run_first_cycle: req=%b state=%0d required 0 %0d", imem_bus.req_valid, dbg_state, ST_FETCH);
    end
    cyc(1);
    checks++;
    if (imem_bus.req_valid !== 1'b1 || imem_bus.addr !== RESET_PC) begin
      failures++;
      $display("FAIL run_req: req=%b addr=%h required 1 %h", imem_bus.req_valid, imem_bus.addr, RESET_PC);
    end
  endtask

  task automatic test_sequential();
    bit ok;
    run_instr(32'h0050_0093, 3, 5, 0, 1'b0, 32'h0, 1'b1);
    wait_imem_req(ok);
    checks++;
    if (imem_bus.addr !== 32'h4 || retired !== 32'd1) begin
      failures++;
      $display("FAIL sequential: addr=%h retired=%0d required 4 1", imem_bus.addr, retired);
    end
  endtask

  task automatic test_redirect();
    bit ok;
    run_instr(32'h1000_006f, 1, 2, 1, 1'b1, 32'h0000_0100, 1'b1);
    wait_imem_req(ok);
    checks++;
    if (imem_bus.addr !== 32'h100 || retired !== 32'd2) begin
      failures++;
      $display("FAIL redirect: addr=%h retired=%0d required 100 2", imem_bus.addr, retired);
    end
  endtask

  task automatic test_stray();
    bit ok;
    logic [31:0] instr = 32'h00a5_8593;
    fetch_phase(instr, 0);
    wait_dec_req(ok);
    imem_bus.resp_valid = 1'b1;
    imem_bus.rdata      = ~instr;
    exec_done   = 1'b1;
    exec_taken  = 1'b1;
    exec_target = 32'h0000_0203;
    cyc(1);
    imem_bus.resp_valid = 1'b0;
    exec_done = 1'b0;
    checks++;
    if (dec_bus.instruction !== instr || dbg_state !== ST_DECODE) begin
      failures++;
      $display("FAIL stray_pulse: instr=%h state=%0d required %h %0d", dec_bus.instruction, dbg_state, instr, ST_DECODE);
    end
    checks++;
    if (retired !== m_retired || trap !== 1'b0 || pc !== m_pc) begin
      failures++;
      $display("FAIL stray_regs: retired=%0d trap=%b pc=%h required %0d 0 %h", retired, trap, pc, m_retired, m_pc);
    end
    decode_phase(instr, 0);
    exec_phase(0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_wrap();
    bit ok;
    run_instr(32'h0000_0013, 0, 0, 0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    run_instr(32'h0000_0013, 0, 1, 0, 1'b0, 32'h0, 1'b1);
    wait_imem_req(ok);
    checks++;
    if (imem_bus.addr !== 32'h0 || trap !== 1'b0) begin
      failures++;
      $display("FAIL wrap: addr=%h trap=%b required 0 0", imem_bus.addr, trap);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      run_instr($urandom, $urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 3),
                1'($urandom), $urandom & 32'hFFFF_FFFC, 1'b1);
    end
  endtask

  task automatic test_idle_stop();
    int bad = 0;
    run_instr(32'h0011_0113, 1, 1, 1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      if (imem_bus.req_valid !== 1'b0 || dbg_state !== ST_IDLE) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL idle_hold: %0d bad cycles required 0", bad);
    end
    run = 1'b1;
    exp_q.push_back(m_pc);
    run_instr(32'h0022_0213, 2, 0, 0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_trap();
    int   bad = 0;
    logic [31:0] pc_before;
    pc_before = m_pc;
    run_instr(32'h0020_006f, 0, 1, 0, 1'b1, 32'h0000_0102, 1'b1);
    checks++;
    if (pc !== pc_before) begin
      failures++;
      $display("FAIL trap_pc: got %h required %h", pc, pc_before);
    end
    for (int i = 0; i < 20; i++) begin
      imem_bus.resp_valid = 1'($urandom);
      dec_bus.resp_valid  = 1'($urandom);
      exec_done           = 1'($urandom);
      cyc(1);
      if (imem_bus.req_valid !== 1'b0 || dec_bus.req_valid !== 1'b0 || trap !== 1'b1) bad++;
    end
    imem_bus.resp_valid = 1'b0;
    dec_bus.resp_valid  = 1'b0;
    exec_done           = 1'b0;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL trap_hold: %0d bad cycles required 0", bad);
    end
    apply_reset(1);
    checks++;
    if (trap !== 1'b0 || pc !== RESET_PC || retired !== 32'd0) begin
      failures++;
      $display("FAIL trap_clear: trap=%b pc=%h retired=%0d required 0 %h 0", trap, pc, retired, RESET_PC);
    end
    exp_q.push_back(m_pc);
    run_instr(32'h0000_0013, 0, 0, 0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_mid_reset();
    bit ok;
    run_instr(32'h0033_0313, 1, 1, 0, 1'b0, 32'h0, 1'b1);
    fetch_phase(32'h0044_0413, 1);
    wait_dec_req(ok);
    rst = 1'b1;
    dec_bus.resp_valid = 1'b1;
    cyc(1);
    rst = 1'b0;
    dec_bus.resp_valid = 1'b0;
    model_reset();
    run = 1'b0;
    checks++;
    if (dec_bus.req_valid !== 1'b0 || dbg_state !== ST_IDLE || retired !== 32'd0) begin
      failures++;
      $display("FAIL mid_reset: dec_req=%b state=%0d retired=%0d required 0 0 0", dec_bus.req_valid, dbg_state, retired);
    end
    cyc(2);
    checks++;
    if (dbg_state !== ST_IDLE || imem_bus.req_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_idle: state=%0d req=%b required 0 0", dbg_state, imem_bus.req_valid);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    run = 1'b0;
    exec_done = 1'b0;
    exec_taken = 1'b0;
    exec_target = 32'h0;
    imem_bus.resp_valid = 1'b0;
    imem_bus.rdata = 32'h0;
    dec_bus.resp_valid = 1'b0;
    model_reset();

    test_reset();
    test_sequential();
    test_redirect();
    test_stray();
    test_wrap();
    test_random();
    test_idle_stop();
    test_trap();
    test_mid_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
